// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared types and constants for the RPN calculator controller
// Contents: FSM state enum, ALU op codes (same encoding as ula_8bits),
// default stack depth, data width and a helper telling unary from binary ops.
package rpn_pkg;

    localparam int PROFUNDIDADE_PADRAO = 4;
    localparam int LARGURA             = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        EXECUTA = 2'd2,
        GRAVA   = 2'd3
    } estado_t;

    localparam logic [2:0] OP_SOMA = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    // OP_NOT is the only operation that consumes a single operand.
    function automatic logic op_unaria(input logic [2:0] op);
        return op == OP_NOT;
    endfunction

endpackage

// File: rtl/pilha_rpn.sv
// rtl/pilha_rpn.sv - shift-register operand stack for the RPN controller
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push              shift dado in on top (ignored when full)
//   pop               drop the top entry (ignored when empty)
//   replace           overwrite top with dado; with pop it replaces two entries by one
//   swap              exchange the two top entries
//   dado              write data
//   topo, segundo     entries 0 and 1 (zero when absent)
//   count             number of valid entries
// Entry 0 is always the top. Slots above count are kept at zero so topo and
// segundo read as 0 without any masking logic.
module pilha_rpn
    import rpn_pkg::*;
#(
    parameter  int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    localparam int CW           = $clog2(PROFUNDIDADE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               replace,
    input  logic               swap,
    input  logic [LARGURA-1:0] dado,
    output logic [LARGURA-1:0] topo,
    output logic [LARGURA-1:0] segundo,
    output logic [CW-1:0]      count
);

    logic [LARGURA-1:0] mem  [PROFUNDIDADE];
    logic [LARGURA-1:0] prox [PROFUNDIDADE];
    logic [CW-1:0]      prox_count;

    always_comb begin
        prox       = mem;
        prox_count = count;
        if (push) begin
            if (count < CW'(PROFUNDIDADE)) begin
                for (int i = PROFUNDIDADE - 1; i > 0; i--) begin
                    prox[i] = mem[i-1];
                end
                prox[0]    = dado;
                prox_count = count + CW'(1);
            end
        end else begin
            // pop is applied first so that pop+replace turns (b, a, ...) into (dado, ...)
            if (pop && count != '0) begin
                for (int i = 0; i < PROFUNDIDADE - 1; i++) begin
                    prox[i] = mem[i+1];
                end
                prox[PROFUNDIDADE-1] = '0;
                prox_count           = count - CW'(1);
            end
            if (replace) begin
                prox[0] = dado;
            end
            if (swap) begin
                prox[0] = mem[1];
                prox[1] = mem[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                mem[i] <= '0;
            end
            count <= '0;
        end else begin
            mem   <= prox;
            count <= prox_count;
        end
    end

    assign topo    = mem[0];
    assign segundo = mem[1];

endmodule

// File: rtl/controlador_rpn.sv
// rtl/controlador_rpn.sv - RPN calculator controller driving an external 8-bit ALU
// Optional feature: define RPN_SWAP_EN to add the cmd_swap port and swap logic.
// Ports:
//   CLOCK_50, rst_n                       clock, asynchronous active-low reset
//   entrada, op_in                        operand to push, ALU op code
//   cmd_push, cmd_op (, cmd_swap)         single-cycle command pulses
//   ula_a, ula_b, ula_op                  registered ALU operands/op
//   ula_resultado, ula_overflow, ula_zero, ula_carry, ula_erro   ALU outputs
//   topo, segundo                         top two stack entries
//   pilha_vazia, pilha_cheia, ocupado, erro, flags{ovf,zero,carry,erro_ula}
module controlador_rpn
    import rpn_pkg::*;
#(
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] entrada,
    input  logic [2:0]         op_in,
    input  logic               cmd_push,
    input  logic               cmd_op,
`ifdef RPN_SWAP_EN
    input  logic               cmd_swap,
`endif
    output logic [LARGURA-1:0] ula_a,
    output logic [LARGURA-1:0] ula_b,
    output logic [2:0]         ula_op,
    input  logic [LARGURA-1:0] ula_resultado,
    input  logic               ula_overflow,
    input  logic               ula_zero,
    input  logic               ula_carry,
    input  logic               ula_erro,
    output logic [LARGURA-1:0] topo,
    output logic [LARGURA-1:0] segundo,
    output logic               pilha_vazia,
    output logic               pilha_cheia,
    output logic               ocupado,
    output logic               erro,
    output logic [3:0]         flags
);

    localparam int CW = $clog2(PROFUNDIDADE + 1);

    estado_t            estado, prox_estado;
    logic [CW-1:0]      count;
    logic [LARGURA-1:0] resultado;

    logic               push_s, pop_s, replace_s, swap_s;
    logic [LARGURA-1:0] dado_s;
    logic               aceita_op, erro_set, erro_clr;

    pilha_rpn #(.PROFUNDIDADE(PROFUNDIDADE)) u_pilha (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .replace (replace_s),
        .swap    (swap_s),
        .dado    (dado_s),
        .topo    (topo),
        .segundo (segundo),
        .count   (count)
    );

    assign pilha_vazia = (count == '0);
    assign pilha_cheia = (count == CW'(PROFUNDIDADE));
    assign ocupado     = (estado != OCIOSO);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        replace_s   = 1'b0;
        swap_s      = 1'b0;
        dado_s      = entrada;
        aceita_op   = 1'b0;
        erro_set    = 1'b0;
        erro_clr    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (cmd_push) begin
                    if (pilha_cheia) begin
                        erro_set = 1'b1;
                    end else begin
                        push_s   = 1'b1;
                        erro_clr = 1'b1;
                    end
                end else if (cmd_op) begin
                    if (count >= (op_unaria(op_in) ? CW'(1) : CW'(2))) begin
                        aceita_op   = 1'b1;
                        prox_estado = CARREGA;
                    end else begin
                        erro_set = 1'b1;
                    end
                end
`ifdef RPN_SWAP_EN
                else if (cmd_swap) begin
                    if (count >= CW'(2)) begin
                        swap_s   = 1'b1;
                        erro_clr = 1'b1;
                    end else begin
                        erro_set = 1'b1;
                    end
                end
`endif
            end
            CARREGA: prox_estado = EXECUTA;
            EXECUTA: prox_estado = GRAVA;
            GRAVA: begin
                prox_estado = OCIOSO;
                // flags[0] holds the ALU error captured in EXECUTA
                if (flags[0]) begin
                    erro_set = 1'b1;
                end else begin
                    replace_s = 1'b1;
                    pop_s     = !op_unaria(ula_op);
                    dado_s    = resultado;
                    erro_clr  = 1'b1;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            ula_a     <= '0;
            ula_b     <= '0;
            ula_op    <= '0;
            resultado <= '0;
            flags     <= '0;
            erro      <= 1'b0;
        end else begin
            if (aceita_op) begin
                ula_a  <= op_unaria(op_in) ? topo : segundo;
                ula_b  <= op_unaria(op_in) ? '0 : topo;
                ula_op <= op_in;
            end
            if (estado == EXECUTA) begin
                resultado <= ula_resultado;
                flags     <= {ula_overflow, ula_zero, ula_carry, ula_erro};
            end
            if (erro_set) begin
                erro <= 1'b1;
            end else if (erro_clr) begin
                erro <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_controlador_rpn.sv
// tb/tb_controlador_rpn.sv - scoreboard bench for controlador_rpn with a behavioural ALU
module tb_controlador_rpn;
    import rpn_pkg::*;

    localparam int PROF = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] entrada;
    logic [2:0] op_in;
    logic       cmd_push, cmd_op;
`ifdef RPN_SWAP_EN
    logic       cmd_swap;
`endif
    logic [7:0] ula_a, ula_b, ula_resultado;
    logic [2:0] ula_op;
    logic       ula_overflow, ula_zero, ula_carry, ula_erro;
    logic [7:0] topo, segundo;
    logic       pilha_vazia, pilha_cheia, ocupado, erro;
    logic [3:0] flags;

    controlador_rpn #(.PROFUNDIDADE(PROF)) dut (
        .CLOCK_50      (clk),
        .rst_n         (rst_n),
        .entrada       (entrada),
        .op_in         (op_in),
        .cmd_push      (cmd_push),
        .cmd_op        (cmd_op),
`ifdef RPN_SWAP_EN
        .cmd_swap      (cmd_swap),
`endif
        .ula_a         (ula_a),
        .ula_b         (ula_b),
        .ula_op        (ula_op),
        .ula_resultado (ula_resultado),
        .ula_overflow  (ula_overflow),
        .ula_zero      (ula_zero),
        .ula_carry     (ula_carry),
        .ula_erro      (ula_erro),
        .topo          (topo),
        .segundo       (segundo),
        .pilha_vazia   (pilha_vazia),
        .pilha_cheia   (pilha_cheia),
        .ocupado       (ocupado),
        .erro          (erro),
        .flags         (flags)
    );

    // Behavioural ula_8bits: returns {resultado, overflow, zero, carry, erro}
    function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        ov, cy, er;
        s = '0; p = '0; r = '0; ov = 1'b0; cy = 1'b0; er = 1'b0;
        case (op)
            OP_SOMA: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cy = s[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
            OP_SUB:  begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; cy = s[8]; ov = (a[7] != b[7]) && (r[7] != a[7]); end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MUL:  begin p = {8'h00, a} * {8'h00, b}; r = p[7:0]; ov = |p[15:8]; end
            OP_DIV:  begin if (b == 8'h00) er = 1'b1; else r = a / b; end
            default: r = ~a;
        endcase
        return {r, ov, (r == 8'h00), cy, er};
    endfunction

    logic [11:0] alu_out;
    assign alu_out = alu_f(ula_op, ula_a, ula_b);
    assign {ula_resultado, ula_overflow, ula_zero, ula_carry, ula_erro} = alu_out;

    typedef struct {
        logic [7:0] topo;
        logic [7:0] segundo;
        logic       erro;
        logic       vazia;
        logic       cheia;
        logic [3:0] flags;
    } exp_t;

    logic [7:0] m_stk[$];
    logic       m_erro;
    logic [3:0] m_flags;
    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void sb_push();
        exp_t e;
        e.topo    = (m_stk.size() > 0) ? m_stk[0] : 8'h00;
        e.segundo = (m_stk.size() > 1) ? m_stk[1] : 8'h00;
        e.erro    = m_erro;
        e.vazia   = (m_stk.size() == 0);
        e.cheia   = (m_stk.size() == PROF);
        e.flags   = m_flags;
        sb.push_back(e);
    endfunction

    task automatic sb_check(input string ctx);
        exp_t e;
        check_eq({ctx, ".sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq({ctx, ".topo"},    32'(topo),        32'(e.topo));
            check_eq({ctx, ".segundo"}, 32'(segundo),     32'(e.segundo));
            check_eq({ctx, ".erro"},    32'(erro),        32'(e.erro));
            check_eq({ctx, ".vazia"},   32'(pilha_vazia), 32'(e.vazia));
            check_eq({ctx, ".cheia"},   32'(pilha_cheia), 32'(e.cheia));
            check_eq({ctx, ".flags"},   32'(flags),       32'(e.flags));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cmd_push = 1'b0; cmd_op = 1'b0;
`ifdef RPN_SWAP_EN
        cmd_swap = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_stk.delete(); m_erro = 1'b0; m_flags = 4'h0; sb.delete();
    endtask

    task automatic do_push(input logic [7:0] v, input string ctx);
        @(negedge clk);
        entrada = v; cmd_push = 1'b1;
        if (m_stk.size() < PROF) begin
            m_stk.push_front(v);
            m_erro = 1'b0;
        end else begin
            m_erro = 1'b1;
        end
        sb_push();
        @(negedge clk);
        cmd_push = 1'b0;
        check_eq({ctx, ".ocupado"}, 32'(ocupado), 32'd0);
        sb_check(ctx);
    endtask

    task automatic do_op(input logic [2:0] op, input bit intrude, input string ctx);
        int          need, busy, exp_busy;
        logic [7:0]  a, b;
        logic [11:0] r;
        a = 8'h00; b = 8'h00;
        @(negedge clk);
        op_in = op; cmd_op = 1'b1;
        need = (op == OP_NOT) ? 1 : 2;
        if (m_stk.size() < need) begin
            m_erro = 1'b1;
            exp_busy = 0;
        end else begin
            exp_busy = 3;
            if (op == OP_NOT) begin a = m_stk[0]; b = 8'h00; end
            else begin a = m_stk[1]; b = m_stk[0]; end
            r = alu_f(op, a, b);
            m_flags = r[3:0];
            if (r[0]) begin
                m_erro = 1'b1;
            end else begin
                m_erro = 1'b0;
                void'(m_stk.pop_front());
                if (op != OP_NOT) void'(m_stk.pop_front());
                m_stk.push_front(r[11:4]);
            end
        end
        sb_push();
        @(negedge clk);
        cmd_op = 1'b0;
        if (exp_busy == 3) begin
            check_eq({ctx, ".ula_a"},  32'(ula_a),  32'(a));
            check_eq({ctx, ".ula_b"},  32'(ula_b),  32'(b));
            check_eq({ctx, ".ula_op"}, 32'(ula_op), 32'(op));
            if (intrude) begin
                entrada = 8'hAA; cmd_push = 1'b1;
            end
        end
        busy = 0;
        while (ocupado && busy < 20) begin
            busy++;
            @(negedge clk);
            cmd_push = 1'b0;
        end
        cmd_push = 1'b0;
        check_eq({ctx, ".busy_cycles"}, 32'(busy), 32'(exp_busy));
        sb_check(ctx);
    endtask

`ifdef RPN_SWAP_EN
    task automatic do_swap(input string ctx);
        logic [7:0] t;
        @(negedge clk);
        cmd_swap = 1'b1;
        if (m_stk.size() >= 2) begin
            t = m_stk[0]; m_stk[0] = m_stk[1]; m_stk[1] = t;
            m_erro = 1'b0;
        end else begin
            m_erro = 1'b1;
        end
        sb_push();
        @(negedge clk);
        cmd_swap = 1'b0;
        sb_check(ctx);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; entrada = 8'h00; op_in = 3'd0; cmd_push = 1'b0; cmd_op = 1'b0;
`ifdef RPN_SWAP_EN
        cmd_swap = 1'b0;
`endif
        m_erro = 1'b0; m_flags = 4'h0;
        @(negedge clk);
        check_eq("rst.topo",    32'(topo),        32'd0);
        check_eq("rst.segundo", 32'(segundo),     32'd0);
        check_eq("rst.vazia",   32'(pilha_vazia), 32'd1);
        check_eq("rst.cheia",   32'(pilha_cheia), 32'd0);
        check_eq("rst.ocupado", 32'(ocupado),     32'd0);
        check_eq("rst.erro",    32'(erro),        32'd0);
        check_eq("rst.flags",   32'(flags),       32'd0);
        check_eq("rst.ula_a",   32'(ula_a),       32'd0);
        check_eq("rst.ula_b",   32'(ula_b),       32'd0);
        check_eq("rst.ula_op",  32'(ula_op),      32'd0);
        rst_n = 1'b1;

        // 5 + 3, with a push attempted while busy
        do_push(8'd5, "soma.p5");
        do_push(8'd3, "soma.p3");
        do_op(OP_SOMA, 1'b1, "soma.op");

        // full stack, blocked pushes, then an op clears erro
        do_reset();
        for (int i = 1; i <= 4; i++) do_push(8'(i), "cheia.fill");
        do_push(8'd9, "cheia.p9");
        do_push(8'd9, "cheia.p9b");
        do_op(OP_SUB, 1'b0, "cheia.sub");

        // operand underflow
        do_reset();
        do_push(8'd7, "under.p7");
        do_op(OP_SOMA, 1'b0, "under.op");

        // division by zero reported by the ALU
        do_reset();
        do_push(8'd10, "div0.p10");
        do_push(8'd0,  "div0.p0");
        do_op(OP_DIV, 1'b0, "div0.op");

        // unary NOT on a single operand
        do_reset();
        do_push(8'h3C, "not.p");
        do_op(OP_NOT, 1'b0, "not.op");

        // random command mix
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_op(3'($urandom_range(0, 7)), 1'b0, "rand.op");
            else
                do_push(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)), "rand.push");
        end

        // push wins over a simultaneous op
        do_reset();
        do_push(8'd1, "prio.p1");
        @(negedge clk);
        entrada = 8'd2; cmd_push = 1'b1; op_in = OP_SOMA; cmd_op = 1'b1;
        m_stk.push_front(8'd2); m_erro = 1'b0;
        sb_push();
        @(negedge clk);
        cmd_push = 1'b0; cmd_op = 1'b0;
        check_eq("prio.ocupado", 32'(ocupado), 32'd0);
        sb_check("prio");

        // reset asserted while in EXECUTA
        @(negedge clk);
        op_in = OP_SOMA; cmd_op = 1'b1;
        @(negedge clk);
        cmd_op = 1'b0;
        @(negedge clk);
        check_eq("abort.ocupado_pre", 32'(ocupado), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort.topo",    32'(topo),        32'd0);
        check_eq("abort.segundo", 32'(segundo),     32'd0);
        check_eq("abort.ocupado", 32'(ocupado),     32'd0);
        check_eq("abort.vazia",   32'(pilha_vazia), 32'd1);
        check_eq("abort.ula",     32'({ula_a, ula_b, ula_op}), 32'd0);
        check_eq("abort.flags",   32'(flags),       32'd0);
        check_eq("abort.erro",    32'(erro),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort.post_topo",    32'(topo),    32'd0);
        check_eq("abort.post_ocupado", 32'(ocupado), 32'd0);

`ifdef RPN_SWAP_EN
        do_reset();
        do_push(8'd2, "swap.p2");
        do_push(8'd6, "swap.p6");
        do_swap("swap.ok");
        do_reset();
        do_push(8'd1, "swap.p1");
        do_swap("swap.under");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_rpn.md
CONTROLADOR_RPN -- requirements
Module: controlador_rpn

Interface
REQ-001 SHALL have parameter PROFUNDIDADE, default 4: number of 8-bit stack entries (2..8).
REQ-002 SHALL have port CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port entrada  in  8  operand value to push.
REQ-005 SHALL have port op_in  in  3  ALU operation code, sampled with cmd_op.
REQ-006 SHALL have ports cmd_push, cmd_op  in  1 each  single-cycle command pulses.
REQ-007 SHALL have port cmd_swap  in  1  swap command; present only with RPN_SWAP_EN.
REQ-008 SHALL have ports ula_a, ula_b  out  8 each, and ula_op  out  3: registered drive to ula_8bits.
REQ-009 SHALL have ports ula_resultado  in  8, and ula_overflow, ula_zero, ula_carry, ula_erro  in  1 each: ALU outputs.
REQ-010 SHALL have ports topo, segundo  out  8 each  top two stack entries, 0 when absent.
REQ-011 SHALL have ports pilha_vazia, pilha_cheia, ocupado, erro  out  1 each, and flags  out  4  {overflow,zero,carry,erro_ula}.

Function
REQ-012 SHALL implement FSM states OCIOSO, CARREGA, EXECUTA, GRAVA; ocupado=1 in every state except OCIOSO.
REQ-013 SHALL accept commands only in OCIOSO; commands arriving while ocupado=1 SHALL be ignored with no error.
REQ-014 Priority on simultaneous pulses SHALL be cmd_push > cmd_op > cmd_swap; losers are dropped.
REQ-015 cmd_push with count<PROFUNDIDADE SHALL write entrada to top and increment count on the same edge.
REQ-016 cmd_push with count==PROFUNDIDADE SHALL leave stack unchanged and set erro.
REQ-017 cmd_op with op_in==OP_NOT SHALL require count>=1; all other codes SHALL require count>=2; otherwise stack unchanged, erro set, stay in OCIOSO.
REQ-018 Valid cmd_op: OCIOSO->CARREGA registers ula_a=segundo (topo for OP_NOT), ula_b=topo (0 for OP_NOT), ula_op=op_in.
REQ-019 CARREGA->EXECUTA unconditionally (one settle cycle for the combinational ALU).
REQ-020 EXECUTA->GRAVA: capture ula_resultado and the four ALU flags into flags.
REQ-021 GRAVA: when ula_erro=0, pop consumed operands (1 or 2) and push the result; when ula_erro=1, stack unchanged and erro set; then ->OCIOSO.
REQ-022 Stack update SHALL be visible on topo three cycles after the edge accepting cmd_op.
REQ-023 erro SHALL be sticky; it SHALL clear on the next accepted command that completes without error.
REQ-024 pilha_vazia = (count==0); pilha_cheia = (count==PROFUNDIDADE), both combinational from registered count.
REQ-025 Count SHALL never wrap; overflow/underflow are prevented only by REQ-016/REQ-017.

Reset
REQ-026 rst_n low SHALL immediately force: state OCIOSO, count 0, all entries 0, ula_a/ula_b/ula_op 0, flags 0, erro 0.
REQ-027 Reset asserted mid-operation SHALL abort it; no partial stack write SHALL survive.

Configuration
REQ-028 With RPN_SWAP_EN defined, a valid cmd_swap (count>=2) SHALL exchange topo and segundo in one cycle; with count<2 it SHALL set erro.
REQ-029 Without RPN_SWAP_EN, port cmd_swap and its logic SHALL be absent.

Structure
REQ-030 Package rpn_pkg SHALL hold FSM state enum, op codes (OP_SOMA..OP_NOT matching ula_8bits) and PROFUNDIDADE default.
REQ-031 Stack storage SHALL be sub-module pilha_rpn (push/pop/replace/swap ports, count output); FSM remains in controlador_rpn.

Verification
REQ-032 Reset, push 5, push 3, cmd_op=SOMA -> ocupado 3 cycles, topo=8, count=1, erro=0.
REQ-033 Push 4 values then push 9 -> erro=1, pilha_cheia=1, topo unchanged; next valid push blocked, then pop via op clears erro.
REQ-034 Push 7, cmd_op=SOMA -> erro=1, topo=7, no state leaves OCIOSO.
REQ-035 Push 10, push 0, cmd_op=DIV with ula_erro=1 -> flags[0]=1, erro=1, topo=0, segundo=10.
REQ-036 Push 1, cmd_push and cmd_op in same cycle -> push taken, count=2, op dropped; rst_n low in EXECUTA -> all outputs 0 immediately.
REQ-037 With RPN_SWAP_EN: push 2, push 6, cmd_swap -> topo=2, segundo=6 next cycle.
